bennett_sequencer: RTL and testbench
====================================

Name: bennett_sequencer

Overview:
- Run controller for the Bennett-clocked adiabatic ALU pipeline.
- Generates the staged thermometer rail pair (clkp/clkn) that powers the ALU stages. Each run has a start/busy/done handshake, a programmable hold at full charge, and a one-cycle capture strobe for result sampling.
- Sits between the ALU issue logic and the adiabatic stage array. Replaces a free-running ramp with a demand-driven, request-sequenced one.

Parameters:
- WIDTH, 11, number of Bennett clock stages (>= 2)
- STEP_CYCLES, 1, ext_clk cycles per stage step during ramp (>= 1)
- HOLD_W, 4, width of hold_len
- LVL_W, $clog2(WIDTH+1), width of level output (derived, do not override)

Ports:
- ext_clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- hold_len  in  HOLD_W  hold duration code, latched at start accept
- busy  out  1  run in progress
- capture  out  1  one-cycle result-capture strobe
- done  out  1  one-cycle run-complete pulse
- level  out  LVL_W  number of stages currently charged
- clkp  out  WIDTH  stage rails, thermometer, bit i high iff i < level
- clkn  out  WIDTH  always ~clkp
- (optional) abort  in  1; aborted  out  1; see Optional Feature

Behaviour:
- Reset (async, immediate):
  - state=IDLE, level=0, clkp=0, clkn=all-ones
  - busy=0, capture=0, done=0, step counter=0, aborted=0
  - Reset mid-run drops all stages at once; no ramp-down.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN. All outputs are registered.
- IDLE:
  - start=1 at an edge → RAMP_UP; level←1; busy←1; latch hold_len; step counter←0.
  - start=0 → remain in IDLE.
- RAMP_UP:
  - level increments every STEP_CYCLES edges; stage 0 charges first.
  - The edge that makes level=WIDTH also enters HOLD.
- HOLD:
  - Lasts latched hold_len+1 cycles.
  - capture=1 during the last HOLD cycle only.
  - The edge ending HOLD sets level←WIDTH-1 (stage WIDTH-1 discharges first) and enters RAMP_DOWN.
- RAMP_DOWN:
  - level decrements every STEP_CYCLES edges, highest stage first.
  - The edge that sets level=0 enters IDLE, busy←0, done←1 for exactly one cycle.
- Timing:
  - busy high for 2*(WIDTH-1)*STEP_CYCLES + hold_len + 1 cycles.
  - clkp all-ones for exactly hold_len+1 cycles.
- Handshake:
  - start is ignored while busy.
  - start high during the done cycle is accepted (back-to-back runs, no gap cycle).
  - hold_len changes after accept have no effect on the current run.
- Invariants checked by the bench:
  - level changes by at most 1 per edge.
  - clkp is always a thermometer code.
  - clkn==~clkp every cycle.
  - capture and done are never both high.

Optional Feature:
- Macro: BENNETT_SEQ_ABORT_EN.
- Defined:
  - Adds port abort (in, 1) and port aborted (out, 1).
  - abort=1 at an edge in RAMP_UP or HOLD: level←level-1, state←RAMP_DOWN (or IDLE if level reaches 0), aborted←1.
  - capture is suppressed for that run.
  - Ramp-down then proceeds normally and done pulses as usual.
  - aborted holds until the next start accept, which clears it.
  - abort is ignored in IDLE and RAMP_DOWN. In IDLE, start wins over a simultaneous abort.
- Undefined:
  - Neither abort nor aborted exists.
  - Every run completes the full ramp and hold.

Test Plan:
- Reset 2 cycles, start pulse, WIDTH=11, STEP_CYCLES=1, hold_len=2 → level 1..11 on successive edges, clkp=11'h7FF for 3 cycles, capture in 3rd, level 10..0, busy 23 cycles, done one cycle.
- STEP_CYCLES=3, hold_len=0 → each level held 3 cycles, clkp all-ones 1 cycle with capture, busy 61 cycles.
- start held high continuously, hold_len=1 → second run begins on the done cycle (level=1 next cycle), start pulses while busy produce no extra runs.
- Assert reset when level=6 in RAMP_UP → same time step clkp=0, clkn=all-ones, busy=0, no done; a new start afterwards runs normally.
- hold_len=15 latched, hold_len changed to 0 mid-run → hold still 16 cycles.
- BENNETT_SEQ_ABORT_EN: abort at level=4 in RAMP_UP → level 3,2,1,0, no capture, done pulse, aborted=1 until next start; abort in IDLE with start → run starts, aborted=0.

Source files
------------

// File: rtl/bennett_sequencer.sv
// Bennett-clock run sequencer: ramps a thermometer rail pair up one stage at
// a time, holds at full charge for a programmable time with a capture strobe
// on the last hold cycle, then ramps back down and pulses done.
// Optional abort support is compiled in with BENNETT_SEQ_ABORT_EN.
module bennett_sequencer #(
  parameter int WIDTH       = 11,
  parameter int STEP_CYCLES = 1,
  parameter int HOLD_W      = 4,
  parameter int LVL_W       = $clog2(WIDTH + 1)
) (
  input  logic              ext_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
`ifdef BENNETT_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              capture,
  output logic              done,
  output logic [LVL_W-1:0]  level,
  output logic [WIDTH-1:0]  clkp,
  output logic [WIDTH-1:0]  clkn
);

  localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(WIDTH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;

  state_t            state;
  logic [SC_W-1:0]   step_cnt;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              abort_req;

`ifdef BENNETT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Thermometer code: bit i set iff i < l (stage 0 charges first).
  function automatic logic [WIDTH-1:0] therm(input logic [LVL_W-1:0] l);
    logic [WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < WIDTH; i++) t[i] = (i < int'(l));
    return t;
  endfunction

  // Run FSM; rails are registered alongside level so they never lag it.
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      level    <= '0;
      clkp     <= '0;
      clkn     <= '1;
      busy     <= 1'b0;
      capture  <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
`ifdef BENNETT_SEQ_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      capture <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          // start beats a simultaneous abort; abort is meaningless here
          if (start) begin
            state    <= RAMP_UP;
            level    <= LVL_ONE;
            clkp     <= therm(LVL_ONE);
            clkn     <= ~therm(LVL_ONE);
            busy     <= 1'b1;
            hold_q   <= hold_len;
            step_cnt <= '0;
`ifdef BENNETT_SEQ_ABORT_EN
            aborted  <= 1'b0;
`endif
          end
        end
        RAMP_UP, HOLD: begin
          if (abort_req) begin
            // Drop one stage now and fall into the normal ramp-down path
            level    <= level - LVL_ONE;
            clkp     <= therm(level - LVL_ONE);
            clkn     <= ~therm(level - LVL_ONE);
            step_cnt <= '0;
            if (level == LVL_ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RAMP_DOWN;
            end
`ifdef BENNETT_SEQ_ABORT_EN
            aborted  <= 1'b1;
`endif
          end else if (state == RAMP_UP) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              level    <= level + LVL_ONE;
              clkp     <= therm(level + LVL_ONE);
              clkn     <= ~therm(level + LVL_ONE);
              if (level + LVL_ONE == LVL_FULL) begin
                state    <= HOLD;
                hold_cnt <= hold_q;
                capture  <= (hold_q == '0);
              end
            end else begin
              step_cnt <= step_cnt + SC_W'(1);
            end
          end else begin
            // HOLD: hold_cnt counts remaining cycles after the current one
            if (hold_cnt == '0) begin
              state    <= RAMP_DOWN;
              step_cnt <= '0;
              level    <= LVL_FULL - LVL_ONE;
              clkp     <= therm(LVL_FULL - LVL_ONE);
              clkn     <= ~therm(LVL_FULL - LVL_ONE);
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
              capture  <= (hold_cnt == HOLD_W'(1));
            end
          end
        end
        RAMP_DOWN: begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            level    <= level - LVL_ONE;
            clkp     <= therm(level - LVL_ONE);
            clkn     <= ~therm(level - LVL_ONE);
            if (level == LVL_ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + SC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bennett_sequencer.sv
// Bench for bennett_sequencer: per-run scoreboard plus per-cycle invariants
// on the STEP_CYCLES=1 instance, direct checks on a STEP_CYCLES=3 instance.
module tb_bennett_sequencer;
  localparam int W  = 11;
  localparam int HW = 4;
  localparam int LW = $clog2(W + 1);

  logic ext_clk = 1'b0;
  logic reset   = 1'b1;

  logic          start_a = 1'b0, start_b = 1'b0;
  logic [HW-1:0] hold_a = '0, hold_b = '0;
  logic          busy_a, capture_a, done_a, busy_b, capture_b, done_b;
  logic [LW-1:0] level_a, level_b;
  logic [W-1:0]  clkp_a, clkn_a, clkp_b, clkn_b;
`ifdef BENNETT_SEQ_ABORT_EN
  logic abort_a = 1'b0, abort_b = 1'b0;
  logic aborted_a, aborted_b;
`endif

  always #5 ext_clk = ~ext_clk;

  bennett_sequencer #(.WIDTH(W), .STEP_CYCLES(1), .HOLD_W(HW)) u_dut_a (
    .ext_clk(ext_clk), .reset(reset), .start(start_a), .hold_len(hold_a),
`ifdef BENNETT_SEQ_ABORT_EN
    .abort(abort_a), .aborted(aborted_a),
`endif
    .busy(busy_a), .capture(capture_a), .done(done_a), .level(level_a),
    .clkp(clkp_a), .clkn(clkn_a));

  bennett_sequencer #(.WIDTH(W), .STEP_CYCLES(3), .HOLD_W(HW)) u_dut_b (
    .ext_clk(ext_clk), .reset(reset), .start(start_b), .hold_len(hold_b),
`ifdef BENNETT_SEQ_ABORT_EN
    .abort(abort_b), .aborted(aborted_b),
`endif
    .busy(busy_b), .capture(capture_b), .done(done_b), .level(level_b),
    .clkp(clkp_b), .clkn(clkn_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int busy_len;
    int full_len;
    int caps;
    int cap_pos;
  } run_t;
  run_t sb[$];

  function automatic run_t exp_run(input int hold, input int step);
    run_t r;
    r.busy_len = 2 * (W - 1) * step + hold + 1;
    r.full_len = hold + 1;
    r.caps     = 1;
    r.cap_pos  = hold + 1;
    return r;
  endfunction

  // Monitor for instance A: invariants every cycle, run summary at done
  int bcnt, fcnt, ccnt, cpos, prev_lvl;
  always @(negedge ext_clk) begin
    logic [W-1:0] inv, th;
    int d;
    run_t r;
    if (reset) begin
      bcnt = 0; fcnt = 0; ccnt = 0; cpos = 0; prev_lvl = 0;
    end else begin
      inv = ~clkp_a;
      th  = W'((64'd1 << level_a) - 64'd1);
      chk("clkn_inv", clkn_a, inv);
      chk("therm", clkp_a, th);
      d = int'(level_a) - prev_lvl;
      chk("lvl_step", (d >= -1 && d <= 1), 1);
      prev_lvl = int'(level_a);
      chk("cap_and_done", capture_a & done_a, 0);
      if (busy_a) begin
        bcnt++;
        if (clkp_a == '1) fcnt++;
        if (capture_a) begin ccnt++; cpos = fcnt; end
      end
      if (done_a) begin
        chk("done_busy_low", busy_a, 0);
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          r = sb.pop_front();
          chk("run_busy_len", bcnt, r.busy_len);
          chk("run_full_len", fcnt, r.full_len);
          chk("run_caps", ccnt, r.caps);
          chk("run_cap_pos", cpos, r.cap_pos);
        end
        bcnt = 0; fcnt = 0; ccnt = 0; cpos = 0;
      end
    end
  end

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    do begin
      @(negedge ext_clk);
      n++;
    end while (!done_a && n < max);
    chk(tag, done_a, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, oc, cc, run, pl;
    run_t r;
    repeat (2) @(negedge ext_clk);
    chk("rst_level", level_a, 0);
    chk("rst_clkp", clkp_a, 0);
    chk("rst_clkn", clkn_a, 11'h7FF);
    chk("rst_busy", busy_a, 0);
    chk("rst_capture", capture_a, 0);
    chk("rst_done", done_a, 0);
    reset = 1'b0;
    @(negedge ext_clk);

    // Basic run, STEP_CYCLES=1, hold_len=2
    hold_a = 4'd2;
    sb.push_back(exp_run(2, 1));
    start_a = 1'b1;
    @(negedge ext_clk);
    start_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk("t1_up_level", level_a, i);
      @(negedge ext_clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk("t1_hold_level", level_a, 11);
      chk("t1_hold_clkp", clkp_a, 11'h7FF);
      chk("t1_capture", capture_a, (k == 2));
      @(negedge ext_clk);
    end
    for (int i = 10; i >= 1; i--) begin
      chk("t1_dn_level", level_a, i);
      chk("t1_dn_busy", busy_a, 1);
      @(negedge ext_clk);
    end
    chk("t1_end_level", level_a, 0);
    chk("t1_done", done_a, 1);
    @(negedge ext_clk);
    chk("t1_done_once", done_a, 0);

    // STEP_CYCLES=3, hold_len=0 on instance B
    hold_b = 4'd0;
    start_b = 1'b1;
    @(negedge ext_clk);
    start_b = 1'b0;
    bc = 0; oc = 0; cc = 0; run = 0; pl = 1; n = 0;
    while (!done_b && n < 200) begin
      if (busy_b) bc++;
      if (capture_b) cc++;
      if (clkp_b == '1) oc++;
      if (int'(level_b) != pl) begin
        if (pl >= 1 && pl <= 10) chk("t2_step_len", run, 3);
        run = 1;
        pl = int'(level_b);
      end else run++;
      @(negedge ext_clk);
      n++;
    end
    chk("t2_done", done_b, 1);
    chk("t2_busy_len", bc, 61);
    chk("t2_full_len", oc, 1);
    chk("t2_caps", cc, 1);

    // Back-to-back runs with start held high, hold_len=1
    hold_a = 4'd1;
    sb.push_back(exp_run(1, 1));
    sb.push_back(exp_run(1, 1));
    start_a = 1'b1;
    wait_done("t3_done1", 100);
    @(negedge ext_clk);
    chk("t3_restart_level", level_a, 1);
    chk("t3_restart_busy", busy_a, 1);
    wait_done("t3_done2", 100);
    start_a = 1'b0;
    repeat (3) begin
      @(negedge ext_clk);
      chk("t3_idle_busy", busy_a, 0);
    end

    // Reset mid ramp-up at level 6
    hold_a = 4'd0;
    sb.push_back(exp_run(0, 1));
    start_a = 1'b1;
    @(negedge ext_clk);
    start_a = 1'b0;
    n = 0;
    while (level_a != LW'(6) && n < 20) begin
      @(negedge ext_clk);
      n++;
    end
    chk("t4_reach_lvl6", level_a, 6);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t4_rst_clkp", clkp_a, 0);
    chk("t4_rst_clkn", clkn_a, 11'h7FF);
    chk("t4_rst_busy", busy_a, 0);
    chk("t4_rst_level", level_a, 0);
    @(negedge ext_clk);
    chk("t4_no_done", done_a, 0);
    reset = 1'b0;
    @(negedge ext_clk);
    chk("t4_no_done2", done_a, 0);
    hold_a = 4'd1;
    sb.push_back(exp_run(1, 1));
    start_a = 1'b1;
    @(negedge ext_clk);
    start_a = 1'b0;
    wait_done("t4_rerun_done", 100);

    // hold_len latched at accept
    hold_a = 4'd15;
    sb.push_back(exp_run(15, 1));
    start_a = 1'b1;
    @(negedge ext_clk);
    start_a = 1'b0;
    hold_a = 4'd0;
    wait_done("t5_done", 100);

`ifdef BENNETT_SEQ_ABORT_EN
    // Abort at level 4 during ramp-up
    hold_a = 4'd2;
    r.busy_len = 7; r.full_len = 0; r.caps = 0; r.cap_pos = 0;
    sb.push_back(r);
    start_a = 1'b1;
    @(negedge ext_clk);
    start_a = 1'b0;
    n = 0;
    while (level_a != LW'(4) && n < 20) begin
      @(negedge ext_clk);
      n++;
    end
    chk("ab_reach_lvl4", level_a, 4);
    abort_a = 1'b1;
    @(negedge ext_clk);
    abort_a = 1'b0;
    chk("ab_level3", level_a, 3);
    chk("ab_flag", aborted_a, 1);
    @(negedge ext_clk);
    chk("ab_level2", level_a, 2);
    @(negedge ext_clk);
    chk("ab_level1", level_a, 1);
    @(negedge ext_clk);
    chk("ab_level0", level_a, 0);
    chk("ab_done", done_a, 1);
    @(negedge ext_clk);
    chk("ab_flag_hold", aborted_a, 1);
    // abort with start in IDLE: start wins and clears the flag
    hold_a = 4'd0;
    sb.push_back(exp_run(0, 1));
    abort_a = 1'b1;
    start_a = 1'b1;
    @(negedge ext_clk);
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("ab_idle_start_lvl", level_a, 1);
    chk("ab_cleared", aborted_a, 0);
    wait_done("ab_rerun_done", 100);
`endif

    repeat (3) @(negedge ext_clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
